// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data access path: store/load ops,
// access-unit FSM states, access sizes and the timeout counter width.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_NONE = 3'd0,
    ST_SB   = 3'd1,
    ST_SH   = 3'd2,
    ST_SW   = 3'd3
  } st_op_e;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } ld_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  localparam int TO_CNT_W = 8;

  // A nonzero store op wins over a simultaneous load op; unknown codes act as word ops.
  function automatic size_e op_size(input logic [2:0] st_op, input logic [2:0] ld_op);
    size_e sz;
    sz = SZ_WORD;
    if (st_op != ST_NONE) begin
      case (st_op)
        ST_SB:   sz = SZ_BYTE;
        ST_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (ld_op)
        LD_LB, LD_LBU: sz = SZ_BYTE;
        LD_LH, LD_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] ofs);
    logic mis;
    case (sz)
      SZ_HALF: mis = ofs[0];
      SZ_WORD: mis = |ofs;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] force_align(input size_e sz, input logic [1:0] ofs);
    logic [1:0] res;
    case (sz)
      SZ_HALF: res = {ofs[1], 1'b0};
      SZ_WORD: res = 2'b00;
      default: res = ofs;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational store-data replication / byte-strobe generation and
// load-data extraction with sign or zero extension.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_ofs,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_ofs,
  input  logic [31:0] ld_raw,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    wdata = 32'd0;
    wstrb = 4'b0000;
    case (st_op)
      ST_NONE: begin
        wdata = 32'd0;
        wstrb = 4'b0000;
      end
      ST_SB: begin
        wdata = {4{st_data[7:0]}};
        wstrb = 4'b0001 << st_ofs;
      end
      ST_SH: begin
        wdata = {2{st_data[15:0]}};
        wstrb = st_ofs[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = st_data;
        wstrb = 4'b1111;
      end
    endcase
  end

  assign shifted = ld_raw >> {ld_ofs, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_op)
      LD_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LD_LBU:  ld_data = {24'd0, shifted[7:0]};
      LD_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LD_LHU:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage bus master: one load/store per access, stalls the pipeline until ack or timeout.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned half/word ops instead of forcing alignment.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [2:0]  mem_ram_wdata_op,
  input  logic [2:0]  mem_ram_rdata_op,
  input  logic [31:0] mem_alu_c,
  input  logic [31:0] mem_rD2,
  output logic        stall_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_reg;
  logic [TO_CNT_W-1:0] to_cnt_reg;
  logic [2:0]          ld_op_reg;
  logic [1:0]          ofs_reg;
  logic                bus_req_reg;
  logic                bus_we_reg;
  logic [31:0]         bus_addr_reg;
  logic [3:0]          bus_wstrb_reg;
  logic [31:0]         bus_wdata_reg;
  logic [31:0]         load_data_reg;
  logic                load_valid_reg;
  logic                bus_err_reg;

  logic        access;
  logic        trap;
  logic        accept;
  logic [2:0]  ld_op_eff;
  size_e       size;
  logic [1:0]  ofs_eff;
  logic [31:0] wdata_al;
  logic [3:0]  wstrb_al;
  logic [31:0] ld_ext;

  assign access    = mem_valid && (mem_ram_wdata_op != 3'd0 || mem_ram_rdata_op != 3'd0);
  assign ld_op_eff = (mem_ram_wdata_op != 3'd0) ? 3'd0 : mem_ram_rdata_op;
  assign size      = op_size(mem_ram_wdata_op, mem_ram_rdata_op);
  assign ofs_eff   = force_align(size, mem_alu_c[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = access && is_misaligned(size, mem_alu_c[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign accept   = (state_reg == S_IDLE) && access && !trap;
  assign stall_o  = accept || (state_reg == S_WAIT);
  assign misalign = (state_reg == S_IDLE) && trap;

  mem_lsu_align u_align (
    .st_op   (mem_ram_wdata_op),
    .st_ofs  (ofs_eff),
    .st_data (mem_rD2),
    .ld_op   (ld_op_reg),
    .ld_ofs  (ofs_reg),
    .ld_raw  (bus_rdata),
    .wdata   (wdata_al),
    .wstrb   (wstrb_al),
    .ld_data (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      to_cnt_reg     <= '0;
      ld_op_reg      <= 3'd0;
      ofs_reg        <= 2'd0;
      bus_req_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= 32'd0;
      bus_wstrb_reg  <= 4'd0;
      bus_wdata_reg  <= 32'd0;
      load_data_reg  <= 32'd0;
      load_valid_reg <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      load_valid_reg <= 1'b0;
      bus_err_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_reg     <= S_WAIT;
            to_cnt_reg    <= '0;
            ld_op_reg     <= ld_op_eff;
            ofs_reg       <= ofs_eff;
            bus_req_reg   <= 1'b1;
            bus_we_reg    <= (mem_ram_wdata_op != 3'd0);
            bus_addr_reg  <= {mem_alu_c[31:2], 2'b00};
            bus_wstrb_reg <= wstrb_al;
            bus_wdata_reg <= wdata_al;
          end
        end
        S_WAIT: begin
          // An ack in the final counted cycle still completes normally.
          if (bus_ack) begin
            bus_req_reg <= 1'b0;
            state_reg   <= S_DONE;
            if (ld_op_reg != 3'd0) begin
              load_data_reg  <= ld_ext;
              load_valid_reg <= 1'b1;
            end
          end else if (to_cnt_reg == TO_LAST) begin
            bus_req_reg <= 1'b0;
            bus_err_reg <= 1'b1;
            state_reg   <= S_DONE;
            if (ld_op_reg != 3'd0) begin
              load_data_reg <= 32'd0;
            end
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_CNT_W'(1);
          end
        end
        S_DONE: state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus_req    = bus_req_reg;
  assign bus_we     = bus_we_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_wstrb  = bus_wstrb_reg;
  assign bus_wdata  = bus_wdata_reg;
  assign load_data  = load_data_reg;
  assign load_valid = load_valid_reg;
  assign bus_err    = bus_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT_CYCLES=4) with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [2:0]  mem_ram_wdata_op;
  logic [2:0]  mem_ram_rdata_op;
  logic [31:0] mem_alu_c;
  logic [31:0] mem_rD2;
  logic        stall_o;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_err;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid        (mem_valid),
    .mem_ram_wdata_op (mem_ram_wdata_op),
    .mem_ram_rdata_op (mem_ram_rdata_op),
    .mem_alu_c        (mem_alu_c),
    .mem_rD2          (mem_rD2),
    .stall_o          (stall_o),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_wstrb        (bus_wstrb),
    .bus_wdata        (bus_wdata),
    .bus_ack          (bus_ack),
    .bus_rdata        (bus_rdata),
    .load_data        (load_data),
    .load_valid       (load_valid),
    .bus_err          (bus_err),
    .misalign         (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid        = 1'b0;
    mem_ram_wdata_op = 3'd0;
    mem_ram_rdata_op = 3'd0;
    mem_alu_c        = 32'd0;
    mem_rD2          = 32'd0;
    bus_ack          = 1'b0;
  endtask

  // nwait WAIT cycles; ack (if acked) is driven in the last one, otherwise timeout.
  task automatic txn(input string name, input logic [2:0] st, input logic [2:0] ld,
                     input logic [31:0] addr, input logic [31:0] rd2, input logic [31:0] rdata,
                     input int nwait, input logic acked,
                     input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_wstrb,
                     input logic [31:0] e_wdata, input logic e_lv, input logic e_err,
                     input logic [31:0] e_ld);
    mem_valid        = 1'b1;
    mem_ram_wdata_op = st;
    mem_ram_rdata_op = ld;
    mem_alu_c        = addr;
    mem_rD2          = rd2;
    #1;
    chk({name, ".acc_stall"}, stall_o, 1'b1);
    chk({name, ".acc_req"}, bus_req, 1'b0);
    chk({name, ".acc_mis"}, misalign, 1'b0);
    for (int w = 1; w <= nwait; w++) begin
      step();
      bus_ack   = acked && (w == nwait);
      bus_rdata = rdata;
      #1;
      chk($sformatf("%s.w%0d_req", name, w), bus_req, 1'b1);
      chk($sformatf("%s.w%0d_stall", name, w), stall_o, 1'b1);
      chk($sformatf("%s.w%0d_err", name, w), bus_err, 1'b0);
      if (w == 1 || w == nwait) begin
        chk($sformatf("%s.w%0d_addr", name, w), bus_addr, e_addr);
        chk($sformatf("%s.w%0d_we", name, w), bus_we, e_we);
        chk($sformatf("%s.w%0d_wstrb", name, w), bus_wstrb, e_wstrb);
        chk($sformatf("%s.w%0d_wdata", name, w), bus_wdata, e_wdata);
      end
    end
    step();
    bus_ack = 1'b0;
    #1;
    chk({name, ".done_stall"}, stall_o, 1'b0);
    chk({name, ".done_req"}, bus_req, 1'b0);
    chk({name, ".done_lv"}, load_valid, e_lv);
    chk({name, ".done_err"}, bus_err, e_err);
    chk({name, ".done_ld"}, load_data, e_ld);
    idle_inputs();
    step();
    chk({name, ".post_lv"}, load_valid, 1'b0);
    chk({name, ".post_err"}, bus_err, 1'b0);
    chk({name, ".post_ld"}, load_data, e_ld);
    $display("txn %s addr=%h we=%0d wstrb=%b load_data=%h", name, addr, bus_we, bus_wstrb, load_data);
  endtask

  initial begin
    rst = 1'b1;
    bus_rdata = 32'd0;
    idle_inputs();
    step();
    step();
    chk("rst.stall", stall_o, 1'b0);
    chk("rst.req", bus_req, 1'b0);
    chk("rst.we", bus_we, 1'b0);
    chk("rst.addr", bus_addr, 32'd0);
    chk("rst.wstrb", bus_wstrb, 4'd0);
    chk("rst.wdata", bus_wdata, 32'd0);
    chk("rst.ld", load_data, 32'd0);
    chk("rst.lv", load_valid, 1'b0);
    chk("rst.err", bus_err, 1'b0);
    chk("rst.mis", misalign, 1'b0);
    rst = 1'b0;
    step();

    txn("SW",   3'd3, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1'b1,
        32'h100, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    txn("LB",   3'd0, 3'd1, 32'h102, 32'h0, 32'h0080FF00, 4, 1'b1,
        32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80);
    txn("SB",   3'd1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 1, 1'b1,
        32'h100, 1'b1, 4'b1000, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hFFFFFF80);
    txn("LBU",  3'd0, 3'd2, 32'h102, 32'h0, 32'h0080FF00, 2, 1'b1,
        32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h00000080);
    txn("SH",   3'd2, 3'd0, 32'h202, 32'h1234ABCD, 32'h0, 1, 1'b1,
        32'h200, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 1'b0, 32'h00000080);
    txn("LHU",  3'd0, 3'd4, 32'h100, 32'h0, 32'h0080FF00, 1, 1'b1,
        32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0000FF00);
    txn("LH",   3'd0, 3'd3, 32'h100, 32'h0, 32'h0080FF00, 3, 1'b1,
        32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'hFFFFFF00);
    txn("LW_TO", 3'd0, 3'd5, 32'h200, 32'h0, 32'h12345678, 4, 1'b0,
        32'h200, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0);
    txn("LW",   3'd0, 3'd5, 32'h204, 32'h0, 32'hCAFEF00D, 2, 1'b1,
        32'h204, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D);
    txn("BOTH", 3'd3, 3'd5, 32'h010, 32'h01020304, 32'h99999999, 1, 1'b1,
        32'h010, 1'b1, 4'b1111, 32'h01020304, 1'b0, 1'b0, 32'hCAFEF00D);

`ifdef MEM_MISALIGN_TRAP_EN
    mem_valid        = 1'b1;
    mem_ram_rdata_op = 3'd3;
    mem_alu_c        = 32'h101;
    #1;
    chk("LH101.mis", misalign, 1'b1);
    chk("LH101.stall", stall_o, 1'b0);
    idle_inputs();
    step();
    chk("LH101.req", bus_req, 1'b0);
    chk("LH101.mis_end", misalign, 1'b0);
    chk("LH101.ld", load_data, 32'hCAFEF00D);
    $display("txn LH101 trapped misalign");
`else
    txn("LH101", 3'd0, 3'd3, 32'h101, 32'h0, 32'h12348765, 1, 1'b1,
        32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'hFFFF8765);
`endif

    // Stray ack while idle must not produce a completion.
    bus_ack   = 1'b1;
    bus_rdata = 32'h55555555;
    step();
    bus_ack = 1'b0;
    #1;
    chk("ack_idle.lv", load_valid, 1'b0);
    chk("ack_idle.req", bus_req, 1'b0);
    step();
    chk("ack_idle.lv2", load_valid, 1'b0);
    chk("ack_idle.stall", stall_o, 1'b0);
    $display("txn ACK_IDLE load_data=%h", load_data);

    // Reset in the middle of a WAIT.
    mem_valid        = 1'b1;
    mem_ram_rdata_op = 3'd5;
    mem_alu_c        = 32'h300;
    step();
    chk("rstw.req_before", bus_req, 1'b1);
    rst = 1'b1;
    idle_inputs();
    step();
    chk("rstw.req", bus_req, 1'b0);
    chk("rstw.stall", stall_o, 1'b0);
    chk("rstw.lv", load_valid, 1'b0);
    chk("rstw.err", bus_err, 1'b0);
    chk("rstw.ld", load_data, 32'h0);
    chk("rstw.addr", bus_addr, 32'h0);
    rst = 1'b0;
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    #1;
    chk("rstw.lv_after", load_valid, 1'b0);
    chk("rstw.err_after", bus_err, 1'b0);
    $display("txn RST_IN_WAIT req=%0d stall=%0d", bus_req, stall_o);

    txn("SW2", 3'd3, 3'd0, 32'h404, 32'h87654321, 32'h0, 1, 1'b1,
        32'h404, 1'b1, 4'b1111, 32'h87654321, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
